// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha block driver: FSM states, the sigma constant
// table and the block byte-map layout.
package chacha_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_CONST,
        WR_CTR,
        SETTLE,
        WAIT_RDY,
        RD_ADDR,
        RD_HOLD
    } state_t;

    localparam int          BLOCK_BYTES = 64;
    localparam int          CONST_BYTES = 16;
    localparam logic [5:0]  CTR_BASE    = 6'd48;

    // "expand 32-byte k" with byte 0 in the least-significant lane
    localparam logic [127:0] SIGMA = 128'h6b206574_79622d32_3320646e_61707865;

    function automatic logic [7:0] const_byte(input logic [3:0] idx);
        return SIGMA[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] ctr_byte(input logic [31:0] ctr, input logic [1:0] sel);
        return ctr[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/chacha_driver_if.sv
// Host, keystream and block-side signal bundle of the ChaCha block driver.
// master = driver view, slave = surrounding host / block / consumer view.
interface chacha_driver_if;

    logic [7:0]  cfg_data;
    logic [5:0]  cfg_addr;
    logic        cfg_we;
    logic        cfg_ready;
    logic        start;
    logic        abort;
    logic [31:0] ctr_init;
    logic [7:0]  nblocks;
    logic [7:0]  ks_data;
    logic        ks_valid;
    logic        ks_last;
    logic        ks_ready;
    logic        busy;
    logic        done;
    logic [7:0]  blk_wdata;
    logic [5:0]  blk_addr;
    logic        blk_write;
    logic [7:0]  blk_rdata;
    logic        blk_ready;

    modport master (
        input  cfg_data, cfg_addr, cfg_we, start, abort, ctr_init, nblocks,
        input  ks_ready, blk_rdata, blk_ready,
        output cfg_ready, ks_data, ks_valid, ks_last, busy, done,
        output blk_wdata, blk_addr, blk_write
    );

    modport slave (
        output cfg_data, cfg_addr, cfg_we, start, abort, ctr_init, nblocks,
        output ks_ready, blk_rdata, blk_ready,
        input  cfg_ready, ks_data, ks_valid, ks_last, busy, done,
        input  blk_wdata, blk_addr, blk_write
    );

endinterface

// File: rtl/chacha_driver.sv
// Sequences a ChaCha block: writes constants and counter, waits for ready, streams 64 keystream bytes per block.
// Latency: cfg write appears on the block port 1 cycle later; each keystream byte costs at least 2 cycles.
// Backpressure: ks_ready low holds ks_data/ks_valid stable in RD_HOLD; the block itself is waited on without timeout.
module chacha_driver
    import chacha_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    chacha_driver_if.master bus
);

    state_t      state, state_n;
    logic [31:0] ctr, ctr_n, ctr_inc;
    logic [8:0]  remaining, remaining_n;
    logic [5:0]  rd_idx, rd_idx_n;
    logic        settle, settle_n;
    logic [7:0]  ks_data_q, ks_data_n;
    logic        ks_valid_q, ks_valid_n;
    logic        ks_last_q, ks_last_n;
    logic        done_q, done_n;
    logic        busy_q, busy_n;
    logic        blk_write_q, blk_write_n;
    logic [5:0]  blk_addr_q, blk_addr_n, next_addr;
    logic [7:0]  blk_wdata_q, blk_wdata_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctr         <= '0;
            remaining   <= '0;
            rd_idx      <= '0;
            settle      <= 1'b0;
            ks_data_q   <= '0;
            ks_valid_q  <= 1'b0;
            ks_last_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            blk_write_q <= 1'b0;
            blk_addr_q  <= '0;
            blk_wdata_q <= '0;
        end else begin
            state       <= state_n;
            ctr         <= ctr_n;
            remaining   <= remaining_n;
            rd_idx      <= rd_idx_n;
            settle      <= settle_n;
            ks_data_q   <= ks_data_n;
            ks_valid_q  <= ks_valid_n;
            ks_last_q   <= ks_last_n;
            done_q      <= done_n;
            busy_q      <= busy_n;
            blk_write_q <= blk_write_n;
            blk_addr_q  <= blk_addr_n;
            blk_wdata_q <= blk_wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        ctr_n       = ctr;
        remaining_n = remaining;
        rd_idx_n    = rd_idx;
        settle_n    = settle;
        ks_data_n   = ks_data_q;
        ks_valid_n  = ks_valid_q;
        done_n      = 1'b0;
        blk_write_n = blk_write_q;
        blk_addr_n  = blk_addr_q;
        blk_wdata_n = blk_wdata_q;
        ctr_inc     = ctr + 32'd1;
        next_addr   = blk_addr_q + 6'd1;

        if (bus.abort) begin
            state_n     = IDLE;
            ks_valid_n  = 1'b0;
            blk_write_n = 1'b0;
            rd_idx_n    = '0;
        end else begin
            case (state)
                IDLE: begin
                    blk_write_n = 1'b0;
                    // start takes precedence; a coincident cfg write is dropped
                    if (bus.start) begin
                        ctr_n       = bus.ctr_init;
                        remaining_n = (bus.nblocks == 8'd0) ? 9'd256 : {1'b0, bus.nblocks};
                        rd_idx_n    = '0;
                        state_n     = WR_CONST;
                        blk_write_n = 1'b1;
                        blk_addr_n  = '0;
                        blk_wdata_n = const_byte(4'd0);
                    end else if (bus.cfg_we) begin
                        blk_write_n = 1'b1;
                        blk_addr_n  = bus.cfg_addr;
                        blk_wdata_n = bus.cfg_data;
                    end
                end
                WR_CONST: begin
                    if (blk_addr_q == 6'(CONST_BYTES - 1)) begin
                        state_n     = WR_CTR;
                        blk_addr_n  = CTR_BASE;
                        blk_wdata_n = ctr_byte(ctr, 2'd0);
                    end else begin
                        blk_addr_n  = next_addr;
                        blk_wdata_n = const_byte(next_addr[3:0]);
                    end
                end
                WR_CTR: begin
                    if (blk_addr_q == CTR_BASE + 6'd3) begin
                        state_n     = SETTLE;
                        blk_write_n = 1'b0;
                        settle_n    = 1'b0;
                    end else begin
                        blk_addr_n  = next_addr;
                        blk_wdata_n = ctr_byte(ctr, next_addr[1:0]);
                    end
                end
                SETTLE: begin
                    settle_n = 1'b1;
                    if (settle) state_n = WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (bus.blk_ready) begin
                        state_n    = RD_ADDR;
                        blk_addr_n = rd_idx;
                    end
                end
                RD_ADDR: begin
                    ks_data_n  = bus.blk_rdata;
                    ks_valid_n = 1'b1;
                    state_n    = RD_HOLD;
                end
                RD_HOLD: begin
                    if (bus.ks_ready) begin
                        ks_valid_n = 1'b0;
                        rd_idx_n   = rd_idx + 6'd1;
                        if (rd_idx == 6'(BLOCK_BYTES - 1)) begin
                            ctr_n       = ctr_inc;
                            remaining_n = remaining - 9'd1;
                            if (remaining == 9'd1) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end else begin
                                // key/nonce/constants persist in the block; only the counter changes
                                state_n     = WR_CTR;
                                blk_write_n = 1'b1;
                                blk_addr_n  = CTR_BASE;
                                blk_wdata_n = ctr_inc[7:0];
                            end
                        end else begin
                            state_n    = RD_ADDR;
                            blk_addr_n = rd_idx + 6'd1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n    = (state_n != IDLE);
        ks_last_n = (rd_idx_n == 6'(BLOCK_BYTES - 1));
    end

    assign bus.ks_data   = ks_data_q;
    assign bus.ks_valid  = ks_valid_q;
    assign bus.ks_last   = ks_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cfg_ready = !busy_q;
    assign bus.blk_write = blk_write_q;
    assign bus.blk_addr  = blk_addr_q;
    assign bus.blk_wdata = blk_wdata_q;

endmodule

// File: tb/tb_chacha_driver.sv
// Bench for chacha_driver: behavioural ChaCha20 block beside the driver,
// expected block writes and keystream bytes queued by the stimulus, popped by monitors.
module tb_chacha_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chacha_driver_if bus();
    chacha_driver dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [7:0] sigma_b [16] = '{8'h65, 8'h78, 8'h70, 8'h61, 8'h6e, 8'h64, 8'h20, 8'h33,
                                 8'h32, 8'h2d, 8'h62, 8'h79, 8'h74, 8'h65, 8'h20, 8'h6b};
    logic [7:0] rfc_b [4]    = '{8'h10, 8'hf1, 8'he7, 8'he4};
    logic [7:0] nonce_b [12] = '{8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'h4a,
                                 8'h00, 8'h00, 8'h00, 8'h00};

    logic [8:0]   ks_q [$];
    logic [13:0]  wr_q [$];
    logic [511:0] sh = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] chacha_block(input logic [511:0] st);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
        for (int n = 0; n < 10; n++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + st[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] exp_state(input logic [31:0] c);
        logic [511:0] s;
        s = sh;
        for (int i = 0; i < 16; i++) s[8*i +: 8] = sigma_b[i];
        s[415:384] = c;
        return s;
    endfunction

    // Block model: byte-addressed state, recomputes 6 cycles after the last write
    logic [511:0] mem_bits, out_bits;
    logic [2:0]   lat_cnt;
    logic         blk_rdy;
    always @(posedge clk) begin
        if (rst) begin
            mem_bits <= '0; out_bits <= '0; lat_cnt <= '0; blk_rdy <= 1'b0;
        end else if (bus.blk_write) begin
            mem_bits[{bus.blk_addr, 3'b000} +: 8] <= bus.blk_wdata;
            blk_rdy <= 1'b0;
            lat_cnt <= 3'd6;
        end else if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
                out_bits <= chacha_block(mem_bits);
                blk_rdy  <= 1'b1;
            end
        end
    end
    assign bus.blk_ready = blk_rdy;
    assign bus.blk_rdata = out_bits[{bus.blk_addr, 3'b000} +: 8];

    // Consumer: 0 always ready, 1 random stalls, 2 ready only until abort_at bytes taken
    int rdy_mode = 0;
    int abort_at = 0;
    int ks_cnt = 0, wr_cnt = 0, done_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.ks_ready = 1'b1;
            1:       bus.ks_ready = ($urandom_range(0, 2) != 0);
            default: bus.ks_ready = (ks_cnt < abort_at);
        endcase
    end

    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_dat = '0;
    logic [8:0] ke;
    logic [13:0] we;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            prev_abort = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                check("ks_valid_hold", 64'(bus.ks_valid), 64'd1);
                check("ks_data_hold", 64'(bus.ks_data), 64'(prev_dat));
            end
            if (bus.ks_valid && bus.ks_ready) begin
                ks_cnt++;
                if (ks_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ks_unexpected: got %0h want no byte", bus.ks_data);
                end else begin
                    ke = ks_q.pop_front();
                    check("ks_byte", 64'({bus.ks_last, bus.ks_data}), 64'(ke));
                end
            end
            if (bus.blk_write) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL blk_write_unexpected: got addr %0d data %0h want no write",
                             bus.blk_addr, bus.blk_wdata);
                end else begin
                    we = wr_q.pop_front();
                    check("blk_write", 64'({bus.blk_addr, bus.blk_wdata}), 64'(we));
                end
            end
            if (bus.done) done_cnt++;
            prev_stall = bus.ks_valid && !bus.ks_ready;
            prev_dat   = bus.ks_data;
            prev_abort = bus.abort;
        end
    end

    task automatic push_exp(input logic [31:0] c, input int nblk, input int lim);
        logic [511:0] blk;
        logic [31:0]  cc;
        int n = 0;
        for (int i = 0; i < 16; i++) wr_q.push_back({6'(i), sigma_b[i]});
        for (int b = 0; b < nblk; b++) begin
            cc = c + 32'(b);
            for (int k = 0; k < 4; k++) wr_q.push_back({6'(48 + k), cc[8*k +: 8]});
            blk = chacha_block(exp_state(cc));
            for (int i = 0; i < 64; i++)
                if (n < lim) begin
                    ks_q.push_back({(i == 63), blk[8*i +: 8]});
                    n++;
                end
        end
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        sh[{a, 3'b000} +: 8] = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        check("run_finished_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] c, input logic [7:0] nb8, input bit same_cfg,
                       input bit busy_cfg, input bit rfc);
        int nb, wbase, dbase, kbase;
        nb    = (nb8 == 8'd0) ? 256 : int'(nb8);
        wbase = wr_cnt;
        dbase = done_cnt;
        kbase = ks_q.size();
        push_exp(c, nb, 1 << 30);
        if (rfc) for (int i = 0; i < 4; i++) ks_q[kbase + i] = {1'b0, rfc_b[i]};
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctr_init = c; bus.nblocks = nb8;
        if (same_cfg) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 6'd16; bus.cfg_data = 8'h55;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("cfg_ready_after_start", 64'(bus.cfg_ready), 64'd0);
        if (busy_cfg) begin
            repeat (30) @(posedge clk);
            #1;
            bus.cfg_we = 1'b1; bus.cfg_addr = 6'd20; bus.cfg_data = 8'haa;
            @(posedge clk); #1;
            bus.cfg_we = 1'b0;
        end
        wait_idle(60000);
        check("ks_queue_drained", 64'(ks_q.size()), 64'd0);
        check("wr_count", 64'(wr_cnt - wbase), 64'(16 + 4 * nb));
        check("done_count", 64'(done_cnt - dbase), 64'd1);
        check("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
    endtask

    initial begin
        int dbase;
        rst = 1'b1;
        bus.cfg_data = '0; bus.cfg_addr = '0; bus.cfg_we = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.ctr_init = '0; bus.nblocks = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
        check("rst_ks_valid", 64'(bus.ks_valid), 64'd0);
        check("rst_ks_last", 64'(bus.ks_last), 64'd0);
        check("rst_ks_data", 64'(bus.ks_data), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_blk_write", 64'(bus.blk_write), 64'd0);
        check("rst_blk_addr", 64'(bus.blk_addr), 64'd0);
        check("rst_blk_wdata", 64'(bus.blk_wdata), 64'd0);

        // constant preamble, all-zero key
        run(32'h1234_5678, 8'd1, 1'b0, 1'b0, 1'b0);

        // RFC 7539 block test vector under random stalls
        for (int i = 0; i < 32; i++) cfg_wr(6'(16 + i), 8'(i));
        for (int i = 0; i < 12; i++) cfg_wr(6'(52 + i), nonce_b[i]);
        repeat (2) @(posedge clk);
        rdy_mode = 1;
        run(32'd1, 8'd1, 1'b0, 1'b0, 1'b1);

        // counter wrap across two blocks
        run(32'hffff_ffff, 8'd2, 1'b0, 1'b0, 1'b0);

        // abort while byte 20 is held
        rdy_mode = 2;
        abort_at = ks_cnt + 20;
        dbase = done_cnt;
        push_exp(32'd5, 1, 20);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctr_init = 32'd5; bus.nblocks = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (bus.ks_valid && ks_cnt == abort_at) break;
        end
        check("abort_point_ks_cnt", 64'(ks_cnt), 64'(abort_at));
        check("abort_point_ks_valid", 64'(bus.ks_valid), 64'd1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ks_valid", 64'(bus.ks_valid), 64'd0);
        check("abort_blk_write", 64'(bus.blk_write), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - dbase), 64'd0);
        check("abort_ks_queue", 64'(ks_q.size()), 64'd0);
        check("abort_wr_queue", 64'(wr_q.size()), 64'd0);
        rdy_mode = 0;
        run(32'd7, 8'd1, 1'b0, 1'b0, 1'b0);

        // cfg writes ignored while busy, and dropped when coincident with start
        run(32'h0000_0042, 8'd1, 1'b0, 1'b1, 1'b0);
        run(32'h0000_0043, 8'd1, 1'b1, 1'b0, 1'b0);

        // nblocks = 0 means 256 blocks
        run(32'h0000_0100, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chacha_driver.md
CHACHA_DRIVER -- requirements
Module: chacha_driver

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports cfg_data/cfg_addr/cfg_we, input, 8/6/1, host byte write of key/nonce into block state space.
REQ-004 SHALL have port cfg_ready, output, 1, high when cfg writes are accepted.
REQ-005 SHALL have ports start/abort, input, 1/1, single-cycle command pulses.
REQ-006 SHALL have ports ctr_init/nblocks, input, 32/8, initial block counter and block count (0 = 256), sampled on accepted start.
REQ-007 SHALL have ports ks_data/ks_valid/ks_last, output, 8/1/1, keystream byte stream; ks_last marks byte 63 of each block.
REQ-008 SHALL have port ks_ready, input, 1, stream consumer backpressure.
REQ-009 SHALL have ports busy/done, output, 1/1, run in progress / one-cycle completion pulse.
REQ-010 SHALL have ports blk_wdata/blk_addr/blk_write, output, 8/6/1, drive the block's data_in, addr_in and write.
REQ-011 SHALL have ports blk_rdata/blk_ready, input, 8/1, from the block's data_out and ready.

Function
REQ-012 SHALL drive every block-side and stream output from a register.
REQ-013 SHALL implement FSM states IDLE, WR_CONST, WR_CTR, SETTLE, WAIT_RDY, RD_ADDR, RD_HOLD.
REQ-014 IDLE: cfg_ready=1; a cfg_we cycle SHALL produce blk_write=1 with blk_addr=cfg_addr, blk_wdata=cfg_data on the next cycle.
REQ-015 start in IDLE SHALL load ctr/remaining and enter WR_CONST; start outside IDLE SHALL be ignored; start and cfg_we in the same IDLE cycle: start wins, cfg write dropped.
REQ-016 WR_CONST SHALL write "expand 32-byte k" bytes 0x65,0x78,0x70,0x61,... to addresses 0..15, one byte per cycle.
REQ-017 WR_CTR SHALL write ctr little-endian to addresses 48..51, one byte per cycle, then enter SETTLE.
REQ-018 SETTLE SHALL last exactly 2 cycles with blk_write=0, then enter WAIT_RDY; WAIT_RDY SHALL hold until blk_ready=1, without timeout.
REQ-019 RD_ADDR SHALL drive blk_addr=rd_idx for one cycle; the following edge SHALL capture blk_rdata into ks_data with ks_valid=1 and enter RD_HOLD.
REQ-020 RD_HOLD SHALL keep ks_data/ks_valid stable until ks_valid&&ks_ready; on handshake rd_idx+1 and return to RD_ADDR, so peak rate is 1 byte per 2 cycles.
REQ-021 ks_last SHALL equal 1 exactly while rd_idx=63.
REQ-022 After byte 63 handshake: ctr SHALL increment modulo 2^32 (0xFFFFFFFF wraps to 0), remaining decrements; if remaining reaches 0, go IDLE and pulse done; else go to WR_CTR (constants not rewritten).
REQ-023 busy SHALL be 1 in every state except IDLE; cfg_ready SHALL equal !busy.
REQ-024 abort SHALL force IDLE on the next edge from any state, clearing ks_valid and blk_write, with no done pulse; abort with start in IDLE: abort wins.
REQ-025 Block byte lanes SHALL be little-endian words: word i occupies addresses 4i..4i+3.

Reset
REQ-026 rst SHALL set state=IDLE, ks_valid=0, ks_last=0, ks_data=0, done=0, busy=0, blk_write=0, blk_addr=0, blk_wdata=0, ctr=0, remaining=0, rd_idx=0.
REQ-027 rst mid-run SHALL take priority over all inputs and discard any partial block.

Structure
REQ-028 SHALL place FSM state enum, the 16-byte constant table, CTR_BASE=48 and BLOCK_BYTES=64 in shared package chacha_pkg.
REQ-029 SHALL be a single module with no sub-modules; top-level integration instantiates it beside the existing block.

Verification
REQ-030 Reset, then start with nblocks=1: first 16 blk_write cycles show addr 0..15, data 65 78 70 61 6e 64 20 33 ....
REQ-031 Key 00..1f and nonce 00 00 00 09 00 00 00 4a 00 00 00 00 via cfg, ctr_init=1, nblocks=1 against the real block: ks_data begins 10 f1 e7 e4; 64 bytes; ks_last on the 64th; done once.
REQ-032 ctr_init=0xFFFFFFFF, nblocks=2: second block writes 00 00 00 00 to addresses 48..51.
REQ-033 Random ks_ready stalls: ks_data is stable while ks_valid&&!ks_ready; byte count and order are unchanged.
REQ-034 abort during RD_HOLD of byte 20: next cycle busy=0, ks_valid=0, no done; a new start then completes normally.
REQ-035 cfg_we during busy has no effect on blk_write; cfg_we and start in the same IDLE cycle: no cfg write is issued.
